pc_sel_ctrl: RTL and testbench

//  Sequencer that drives the selection/pc_enable pair consumed by the PC mux.
//  - Decides each cycle whether the PC holds, advances, branches, takes the boot/ISR vector, or clears to 0.
//  - Owns the boot-vector fetch, the interrupt entry sequence (drain, save PC, vector fetch) and exception redirect.
//  - Sits between the decode/hazard logic and the fetch stage.

---
 rtl/pc_sel_ctrl_pkg.sv | 17 +
 rtl/pc_sel_ctrl.sv | 114 +++++++++++
 tb/tb_pc_sel_ctrl.sv | 136 +++++++++++++
 3 files changed

// File: rtl/pc_sel_ctrl_pkg.sv
// rtl/pc_sel_ctrl_pkg.sv - PC mux selection codes and sequencer state encoding
package pc_sel_ctrl_pkg;

   localparam logic [1:0] PC_SEL_NEXT   = 2'b00;
   localparam logic [1:0] PC_SEL_VEC    = 2'b01;
   localparam logic [1:0] PC_SEL_ZERO   = 2'b10;
   localparam logic [1:0] PC_SEL_BRANCH = 2'b11;

   typedef enum logic [2:0] {
      ST_BOOT   = 3'd0,
      ST_RUN    = 3'd1,
      ST_DRAIN  = 3'd2,
      ST_SAVE   = 3'd3,
      ST_VECTOR = 3'd4
   } pc_state_e;

endpackage

// File: rtl/pc_sel_ctrl.sv
// rtl/pc_sel_ctrl.sv - PC select/enable sequencer: boot fetch, interrupt entry, exception redirect
module pc_sel_ctrl
   import pc_sel_ctrl_pkg::*;
#(
   parameter int DRAIN_CYCLES = 3,
   parameter int CNT_W        = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       stall,
   input  logic       branch_taken,
   input  logic       int_req,
   input  logic       exc_req,
   input  logic       vec_valid,
   input  logic       save_done,
   output logic [1:0] selection,
   output logic       pc_enable,
   output logic       flush,
   output logic       vec_req,
   output logic       vec_sel,
   output logic       save_pc,
   output logic       int_ack
);

   pc_state_e        state_q, state_d;
   logic             int_pend_q, int_pend_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_BOOT;
         int_pend_q <= 1'b0;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         int_pend_q <= int_pend_d;
         cnt_q      <= cnt_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      selection = PC_SEL_NEXT;
      pc_enable = 1'b0;
      flush     = 1'b0;
      vec_req   = 1'b0;
      vec_sel   = 1'b0;
      save_pc   = 1'b0;
      int_ack   = 1'b0;

      // Outputs stay at their idle values while reset is held.
      if (!rst) begin
         unique case (state_q)
            ST_BOOT: begin
               vec_req = 1'b1;
               if (vec_valid) begin
                  selection = PC_SEL_VEC;
                  pc_enable = 1'b1;
                  state_d   = ST_RUN;
               end
            end
            ST_RUN: begin
               pc_enable = 1'b1;
               if (exc_req) begin
                  selection = PC_SEL_ZERO;
                  flush     = 1'b1;
               end else if (branch_taken) begin
                  selection = PC_SEL_BRANCH;
                  flush     = 1'b1;
               end else if (int_pend_q) begin
                  pc_enable = 1'b0;
                  flush     = 1'b1;
                  cnt_d     = CNT_W'(DRAIN_CYCLES - 1);
                  state_d   = ST_DRAIN;
               end else if (stall) begin
                  pc_enable = 1'b0;
               end
            end
            ST_DRAIN: begin
               flush = 1'b1;
               if (cnt_q == '0) begin
                  state_d = ST_SAVE;
               end else begin
                  cnt_d = cnt_q - 1'b1;
               end
            end
            ST_SAVE: begin
               save_pc = 1'b1;
               if (save_done) begin
                  state_d = ST_VECTOR;
               end
            end
            ST_VECTOR: begin
               vec_req = 1'b1;
               vec_sel = 1'b1;
               if (vec_valid) begin
                  selection = PC_SEL_VEC;
                  pc_enable = 1'b1;
                  int_ack   = 1'b1;
                  state_d   = ST_RUN;
               end
            end
            default: begin
               state_d = ST_BOOT;
            end
         endcase
      end

      // A request arriving during VECTOR is not latched; ack clears the flag.
      int_pend_d = (int_pend_q | (int_req & (state_q != ST_VECTOR))) & ~int_ack;
   end

endmodule

// File: tb/tb_pc_sel_ctrl.sv
// tb/tb_pc_sel_ctrl.sv - directed-vector bench for pc_sel_ctrl
module tb_pc_sel_ctrl;

   // {selection, pc_enable, flush, vec_req, vec_sel, save_pc, int_ack}
   localparam logic [7:0] O_IDLE   = 8'b00_0_0_0_0_0_0;
   localparam logic [7:0] O_BOOT   = 8'b00_0_0_1_0_0_0;
   localparam logic [7:0] O_BOOTLD = 8'b01_1_0_1_0_0_0;
   localparam logic [7:0] O_NEXT   = 8'b00_1_0_0_0_0_0;
   localparam logic [7:0] O_STALL  = 8'b00_0_0_0_0_0_0;
   localparam logic [7:0] O_BRANCH = 8'b11_1_1_0_0_0_0;
   localparam logic [7:0] O_EXC    = 8'b10_1_1_0_0_0_0;
   localparam logic [7:0] O_DRAIN  = 8'b00_0_1_0_0_0_0;
   localparam logic [7:0] O_SAVE   = 8'b00_0_0_0_0_1_0;
   localparam logic [7:0] O_VWAIT  = 8'b00_0_0_1_1_0_0;
   localparam logic [7:0] O_VLOAD  = 8'b01_1_0_1_1_0_1;

   logic       clk = 1'b0;
   logic       rst, stall, branch_taken, int_req, exc_req, vec_valid, save_done;
   logic [1:0] selection;
   logic       pc_enable, flush, vec_req, vec_sel, save_pc, int_ack;
   logic [7:0] outv;
   int         n_vec = 0;
   int         n_err = 0;

   always #5 clk = ~clk;

   pc_sel_ctrl #(.DRAIN_CYCLES(3), .CNT_W(4)) dut (
      .clk(clk), .rst(rst), .stall(stall), .branch_taken(branch_taken),
      .int_req(int_req), .exc_req(exc_req), .vec_valid(vec_valid),
      .save_done(save_done), .selection(selection), .pc_enable(pc_enable),
      .flush(flush), .vec_req(vec_req), .vec_sel(vec_sel), .save_pc(save_pc),
      .int_ack(int_ack)
   );

   assign outv = {selection, pc_enable, flush, vec_req, vec_sel, save_pc, int_ack};

   task automatic check_vec(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %b expected %b", tag, got, exp);
      end
   endtask

   task automatic clr_in();
      stall = 0; branch_taken = 0; int_req = 0; exc_req = 0; vec_valid = 0; save_done = 0;
   endtask

   // Inputs are set 1 time unit after the rising edge; outputs are checked mid-cycle.
   task automatic cyc(input string tag, input logic [7:0] exp);
      #4;
      check_vec(tag, outv, exp);
      @(posedge clk);
      #1;
      clr_in();
   endtask

   // Called in the first DRAIN cycle: drain, immediate save, immediate vector load.
   task automatic isr_tail(input string tag);
      for (int i = 0; i < 3; i++) cyc({tag, "_drain"}, O_DRAIN);
      save_done = 1; cyc({tag, "_save"}, O_SAVE);
      vec_valid = 1; cyc({tag, "_vload"}, O_VLOAD);
   endtask

   initial begin
      rst = 1; clr_in();
      @(posedge clk); #1;
      cyc("rst_a", O_IDLE);
      rst = 1;
      cyc("rst_b", O_IDLE);
      rst = 0;

      // 1: boot fetch, vector arrives on cycle 5
      for (int i = 0; i < 5; i++) begin
         stall = (i == 2);
         cyc("boot_wait", O_BOOT);
      end
      vec_valid = 1; cyc("boot_load", O_BOOTLD);
      cyc("run_first", O_NEXT);

      // 2: branch beats stall; exception beats branch
      branch_taken = 1; stall = 1; cyc("br_stall", O_BRANCH);
      cyc("br_after", O_NEXT);
      exc_req = 1; branch_taken = 1; cyc("exc_over_br", O_EXC);
      vec_valid = 1; cyc("vv_in_run", O_NEXT);

      // 3: interrupt entry with waits at SAVE and VECTOR
      int_req = 1; cyc("int_pulse", O_NEXT);
      cyc("int_entry", O_DRAIN);
      exc_req = 1; cyc("drain1_exc", O_DRAIN);
      branch_taken = 1; cyc("drain2_br", O_DRAIN);
      cyc("drain3", O_DRAIN);
      vec_valid = 1; cyc("save_wait1", O_SAVE);
      cyc("save_wait2", O_SAVE);
      save_done = 1; cyc("save_done", O_SAVE);
      stall = 1; int_req = 1; cyc("vec_wait", O_VWAIT);
      vec_valid = 1; int_req = 1; cyc("vec_load", O_VLOAD);
      cyc("post_isr1", O_NEXT);
      cyc("post_isr2", O_NEXT);

      // 4: exception and interrupt together
      exc_req = 1; int_req = 1; cyc("exc_int", O_EXC);
      cyc("exc_int_entry", O_DRAIN);
      isr_tail("t4");
      cyc("t4_run", O_NEXT);

      // branch blocks interrupt entry for one cycle
      int_req = 1; cyc("int_pulse2", O_NEXT);
      branch_taken = 1; cyc("br_blocks_int", O_BRANCH);
      cyc("int_entry2", O_DRAIN);
      isr_tail("tb");
      cyc("tb_run", O_NEXT);

      // 5: reset while in SAVE
      int_req = 1; cyc("int_pulse3", O_NEXT);
      cyc("int_entry3", O_DRAIN);
      for (int i = 0; i < 3; i++) cyc("drain_r", O_DRAIN);
      cyc("save_r", O_SAVE);
      rst = 1; save_done = 1; cyc("rst_in_save", O_IDLE);
      rst = 0;
      cyc("boot_after_rst", O_BOOT);
      vec_valid = 1; cyc("boot_load2", O_BOOTLD);
      cyc("no_pend_a", O_NEXT);
      cyc("no_pend_b", O_NEXT);

      // 6: stall held 4 cycles
      for (int i = 0; i < 4; i++) begin
         stall = 1; cyc("stall", O_STALL);
      end
      cyc("stall_drop", O_NEXT);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
